mem_dispatch: RTL and testbench
===============================

MEM_DISPATCH -- requirements
Module: mem_dispatch

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  - REQUEST_SIZE, 38, queue entry width.
  - ADDR_WIDTH, 32, physical address width.
  - DATA_WIDTH, 128, line width.
  - BEAT_WIDTH, 32, bus beat width.
  - CYCLE_NUM_DATA, 4, beats per line.
  - COUNTER_WIDTH, 10, latency counter width.
  - ACCESS_LAT, 8, DRAM access delay in cycles.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have these ports (name, direction, width, meaning), clock and reset first:
  - clk, in, 1, clock.
  - rst, in, 1, async active-low reset.
  - q_empty, in, 1, request queue empty.
  - q_valid, in, 1, queue output valid.
  - q_req, in, 38, popped request.
  - q_pop_en, out, 1, pop strobe to queue.
  - wr_valid, in, 1, write beat offered.
  - wr_data, in, 32, write beat.
  - wr_ready, out, 1, write beat accepted.
  - mem_rd_en, out, 1, array read strobe.
  - mem_wr_en, out, 1, array write strobe.
  - mem_addr, out, 32, line-aligned address.
  - mem_wdata, out, 128, write line.
  - mem_rdata, in, 128, read line, valid 1 cycle after mem_rd_en.
  - rsp_valid, out, 1, response beat valid.
  - rsp_ready, in, 1, consumer accepts beat.
  - rsp_data, out, 32, response beat.
  - rsp_last, out, 1, final beat.
  - rsp_id, out, 4, source id of request.
  - busy, out, 1, high in every state except IDLE.
REQ-004 SHALL decode q_req as [37:36] op (00 read, 01 write, 1x reserved), [35:32] id, [31:0] addr.

Function
REQ-005 SHALL implement FSM states IDLE, POP, CAPT, WDATA, WAIT, ACCESS, RDLAT, RESP.
REQ-006 IDLE: when q_empty=0, go to POP; else stay.
REQ-007 POP: assert q_pop_en for exactly one cycle, then go to CAPT.
REQ-008 CAPT: hold until q_valid=1, then latch op/id/addr.
  - Read -> WAIT.
  - Write -> WDATA.
  - Reserved op -> discard, IDLE.
REQ-009 WDATA: wr_ready=1; each cycle with wr_valid=1 stores wr_data into beat slot n (beat 0 -> bits [31:0], beat 3 -> bits [127:96]). After the 4th accepted beat, go to WAIT.
REQ-010 WAIT: load counter with ACCESS_LAT-1 on entry; decrement each cycle; go to ACCESS at count 0. ACCESS_LAT=0 SHALL bypass WAIT.
REQ-011 ACCESS: assert mem_addr = {addr[31:4],4'b0} for one cycle.
  - Read: assert mem_rd_en, then go to RDLAT.
  - Write: assert mem_wr_en with mem_wdata, then go to IDLE.
REQ-012 RDLAT: latch mem_rdata into the line buffer, go to RESP.
REQ-013 RESP: drive rsp_valid=1, rsp_id = latched id, rsp_data = beat n (low beat first).
  - Advance only when rsp_valid & rsp_ready.
  - rsp_data, rsp_id and rsp_last SHALL be stable while stalled.
  - rsp_last=1 on beat 3 only.
  - After beat 3 is accepted, go to IDLE.
REQ-014 Beat counter SHALL be 2 bits, wrap to 0 on leaving WDATA/RESP; no beat index SHALL exceed 3.
REQ-015 One request in flight only; q_pop_en SHALL never assert outside POP.
REQ-016 wr_ready SHALL be 0 outside WDATA; wr_valid outside WDATA is ignored.
REQ-017 A new pop SHALL occur no earlier than the cycle after return to IDLE; best case read latency from pop to first rsp_valid = ACCESS_LAT+4 cycles.
REQ-018 mem_rd_en and mem_wr_en SHALL never both be 1.

Reset
REQ-019 rst=0 SHALL immediately, independent of clk:
  - force state IDLE.
  - clear counters and latched request.
  - drive q_pop_en, wr_ready, mem_rd_en, mem_wr_en, rsp_valid, rsp_last and busy to 0.
  - drive mem_addr, mem_wdata, rsp_data and rsp_id to 0.
REQ-020 Reset mid-operation SHALL abandon the request; no memory write or response beat SHALL follow it.
REQ-021 After rst deasserts, the first pop SHALL occur no earlier than the second rising edge.

Verification
REQ-022 Read: queue holds {00,4'h3,32'h2222_0000}; mem_rdata=128'h4444_..._1111; rsp_ready=1.
  -> one q_pop_en pulse.
  -> mem_rd_en with mem_addr 32'h2222_0000 after 8 WAIT cycles.
  -> beats 1111..,2222..,3333..,4444.. with rsp_id=3, rsp_last on the 4th.
REQ-023 Write: {01,4'h1,32'h1122_3344}, wr_data 0xA,0xB,0xC,0xD with gaps in wr_valid.
  -> mem_wr_en once, mem_addr 32'h1122_3340, mem_wdata {D,C,B,A}.
  -> no rsp_valid.
REQ-024 Backpressure: read with rsp_ready low 3 cycles on beat 1 -> beat 1 held stable, exactly 4 beats delivered, no duplicates.
REQ-025 Reserved op {10,...} -> popped, no mem strobe, no response, busy low 3 cycles after pop.
REQ-026 Reset asserted during WAIT -> all outputs 0 that same cycle; queue with 2 entries afterward -> both serviced in order.
REQ-027 Back-to-back: 3 queued reads -> 3 pops, each pop only after the previous rsp_last handshake.

Source files
------------

// File: rtl/mem_dispatch.sv
// Single-request memory dispatcher: pops one queued request, gathers write beats
// or waits out the array latency, then performs one line access and streams read beats.
module mem_dispatch #(
  parameter int REQUEST_SIZE   = 38,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int BEAT_WIDTH     = 32,
  parameter int CYCLE_NUM_DATA = 4,
  parameter int COUNTER_WIDTH  = 10,
  parameter int ACCESS_LAT     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_empty,
  input  logic                    q_valid,
  input  logic [REQUEST_SIZE-1:0] q_req,
  output logic                    q_pop_en,
  input  logic                    wr_valid,
  input  logic [BEAT_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [BEAT_WIDTH-1:0]   rsp_data,
  output logic                    rsp_last,
  output logic [3:0]              rsp_id,
  output logic                    busy
);

  // state  | meaning
  // IDLE   | waiting for a non-empty queue
  // POP    | one-cycle pop strobe to the queue
  // CAPT   | waiting for q_valid, latch op/id/addr
  // WDATA  | collecting write beats into the line buffer
  // WAIT   | array access latency countdown
  // ACCESS | single-cycle read or write strobe
  // RDLAT  | capture the read line
  // RESP   | stream read beats to the consumer

  localparam int ID_WIDTH   = 4;
  localparam int BEAT_IDX_W = (CYCLE_NUM_DATA > 1) ? $clog2(CYCLE_NUM_DATA) : 1;
  localparam int OFF_BITS   = $clog2(DATA_WIDTH / 8);
  localparam logic [BEAT_IDX_W-1:0]    LAST_BEAT = BEAT_IDX_W'(CYCLE_NUM_DATA - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAT_LOAD  =
    (ACCESS_LAT > 0) ? COUNTER_WIDTH'(ACCESS_LAT - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0]    OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_CAPT, S_WDATA, S_WAIT, S_ACCESS, S_RDLAT, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [1:0]               req_op;
  logic [ID_WIDTH-1:0]      req_id;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [COUNTER_WIDTH-1:0] lat_cnt;
  logic [BEAT_IDX_W-1:0]    beat_idx;
  logic [DATA_WIDTH-1:0]    line_buf;
  logic [1:0]               q_op;
  logic                     beat_is_last;
  state_t                   after_setup;

  assign q_op         = q_req[REQUEST_SIZE-1 -: 2];
  assign beat_is_last = (beat_idx == LAST_BEAT);
  // A zero access latency skips the countdown entirely.
  assign after_setup  = (ACCESS_LAT > 0) ? S_WAIT : S_ACCESS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!q_empty) state_nxt = S_POP;
      S_POP:    state_nxt = S_CAPT;
      S_CAPT: begin
        if (q_valid) begin
          if (q_op == OP_READ)       state_nxt = after_setup;
          else if (q_op == OP_WRITE) state_nxt = S_WDATA;
          else                       state_nxt = S_IDLE;
        end
      end
      S_WDATA:  if (wr_valid && beat_is_last) state_nxt = after_setup;
      S_WAIT:   if (lat_cnt == '0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = (req_op == OP_READ) ? S_RDLAT : S_IDLE;
      S_RDLAT:  state_nxt = S_RESP;
      S_RESP:   if (rsp_ready && beat_is_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    q_pop_en  = 1'b0;
    wr_ready  = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_id    = '0;
    case (state)
      S_POP:   q_pop_en = 1'b1;
      S_WDATA: wr_ready = 1'b1;
      S_ACCESS: begin
        mem_addr = req_addr & ~OFF_MASK;
        if (req_op == OP_READ) begin
          mem_rd_en = 1'b1;
        end else begin
          mem_wr_en = 1'b1;
          mem_wdata = line_buf;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = line_buf[int'(beat_idx) * BEAT_WIDTH +: BEAT_WIDTH];
        rsp_last  = beat_is_last;
        rsp_id    = req_id;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_op   <= '0;
      req_id   <= '0;
      req_addr <= '0;
      lat_cnt  <= '0;
      beat_idx <= '0;
      line_buf <= '0;
    end else begin
      if (state_nxt == S_WAIT && state != S_WAIT)
        lat_cnt <= LAT_LOAD;
      else if (state == S_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;

      case (state)
        S_CAPT: begin
          if (q_valid) begin
            req_op   <= q_op;
            req_id   <= q_req[ADDR_WIDTH +: ID_WIDTH];
            req_addr <= q_req[ADDR_WIDTH-1:0];
          end
        end
        S_WDATA: begin
          if (wr_valid) begin
            line_buf[int'(beat_idx) * BEAT_WIDTH +: BEAT_WIDTH] <= wr_data;
            beat_idx <= beat_is_last ? '0 : beat_idx + 1'b1;
          end
        end
        S_RDLAT: line_buf <= mem_rdata;
        S_RESP: begin
          if (rsp_ready) beat_idx <= beat_is_last ? '0 : beat_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dispatch.sv
// Directed bench for mem_dispatch: queue, write-source and memory models driven
// on the falling edge, expected values hand-computed per test.
module tb_mem_dispatch;

  logic         clk = 1'b0;
  logic         rst;
  logic         q_empty, q_valid, q_pop_en;
  logic [37:0]  q_req;
  logic         wr_valid, wr_ready;
  logic [31:0]  wr_data;
  logic         mem_rd_en, mem_wr_en;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         rsp_valid, rsp_ready, rsp_last, busy;
  logic [31:0]  rsp_data;
  logic [3:0]   rsp_id;

  mem_dispatch dut (
    .clk(clk), .rst(rst),
    .q_empty(q_empty), .q_valid(q_valid), .q_req(q_req), .q_pop_en(q_pop_en),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_id(rsp_id), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [37:0]  qmem [16];
  int           qhead = 0, qtail = 0;
  bit           pop_seen = 0, rd_seen = 0;
  logic [127:0] rline;
  int           cyc = 0;

  int           npop, nrd, nwr, nb, nlast, nval, first_rsp, rd_cyc, viol = 0;
  int           pop_cyc [8];
  int           last_cyc [8];
  logic [31:0]  rd_addr, wr_addr;
  logic [127:0] wr_line;
  logic [31:0]  bdata [16];
  logic [3:0]   bid [16];
  logic         blast [16];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Queue, memory and monitor all act mid-cycle, where DUT outputs are settled.
  initial forever begin
    @(negedge clk);
    if (q_pop_en && npop < 8) begin pop_cyc[npop] = cyc; npop++; end
    if (mem_rd_en) begin nrd++; rd_addr = mem_addr; rd_cyc = cyc; end
    if (mem_wr_en) begin nwr++; wr_addr = mem_addr; wr_line = mem_wdata; end
    if (mem_rd_en && mem_wr_en) viol++;
    if (rsp_valid) begin
      nval++;
      if (first_rsp < 0) first_rsp = cyc;
    end
    if (rsp_valid && rsp_ready && nb < 16) begin
      bdata[nb] = rsp_data;
      bid[nb]   = rsp_id;
      blast[nb] = rsp_last;
      if (rsp_last && nlast < 8) begin last_cyc[nlast] = cyc; nlast++; end
      nb++;
    end
    q_valid = pop_seen;
    if (pop_seen) begin q_req = qmem[qhead]; qhead++; end
    pop_seen  = q_pop_en;
    q_empty   = (qhead == qtail);
    mem_rdata = rd_seen ? rline : {4{32'hBAD0_BAD0}};
    rd_seen   = mem_rd_en;
  end

  task automatic clear_mon();
    npop = 0; nrd = 0; nwr = 0; nb = 0; nlast = 0; nval = 0;
    first_rsp = -1; rd_cyc = 0; rd_addr = '0; wr_addr = '0; wr_line = '0;
  endtask

  task automatic push(input logic [37:0] e);
    qmem[qtail] = e;
    qtail++;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < max) begin
      @(negedge clk);
      n++;
      if (!busy && q_empty && !pop_seen && !q_valid) idle++;
      else idle = 0;
    end
    chk(tag, idle >= 3, 1'b1);
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!q_pop_en && n < 50);
    chk(tag, q_pop_en, 1'b1);
  endtask

  logic [31:0] wbeat [4];
  logic [37:0] bcat_exp;
  int          n;

  initial begin
    rst = 1'b0; q_empty = 1'b1; q_valid = 1'b0; q_req = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1; mem_rdata = '0;
    clear_mon();
    #12;
    chk("rst_ctl", {q_pop_en, wr_ready, mem_rd_en, mem_wr_en, rsp_valid, rsp_last, busy}, 7'd0);
    chk("rst_data", {mem_addr, rsp_id, rsp_data}, 68'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // read, latency and beat order
    clear_mon();
    rline = 128'h44444444_33333333_22222222_11111111;
    push({2'b00, 4'h3, 32'h2222_0000});
    wait_idle("t1_done", 100);
    chk("t1_pops", npop, 1);
    chk("t1_rd_cnt", nrd, 1);
    chk("t1_rd_addr", rd_addr, 32'h2222_0000);
    chk("t1_rd_lat", rd_cyc - pop_cyc[0], 10);
    chk("t1_rsp_lat", first_rsp - pop_cyc[0], 12);
    chk("t1_nbeats", nb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_beat%0d", i), {bid[i], bdata[i]}, {4'h3, rline[i*32 +: 32]});
    end
    chk("t1_last", {blast[3], blast[2], blast[1], blast[0]}, 4'b1000);
    chk("t1_no_wr", nwr, 0);

    // write with gaps and junk offered before the data phase
    clear_mon();
    wbeat[0] = 32'hA; wbeat[1] = 32'hB; wbeat[2] = 32'hC; wbeat[3] = 32'hD;
    wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF;
    push({2'b01, 4'h1, 32'h1122_3344});
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!wr_ready && n < 50);
      chk($sformatf("t2_ready%0d", i), wr_ready, 1'b1);
      wr_valid = 1'b1; wr_data = wbeat[i];
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_data = 32'hFFFF_FFFF;
      repeat (i + 1) @(posedge clk);
      #1;
    end
    wr_valid = 1'b1;
    wait_idle("t2_done", 100);
    wr_valid = 1'b0;
    chk("t2_wr_cnt", nwr, 1);
    chk("t2_wr_addr", wr_addr, 32'h1122_3340);
    chk("t2_wdata", wr_line, 128'h0000000D_0000000C_0000000B_0000000A);
    chk("t2_no_rsp", nval, 0);
    chk("t2_no_rd", nrd, 0);
    chk("t2_wr_ready_idle", wr_ready, 1'b0);

    // backpressure on beat 1
    clear_mon();
    rline = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    push({2'b00, 4'h5, 32'h0000_1238});
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 60);
    chk("t3_rsp_seen", rsp_valid, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    bcat_exp = {1'b1, 1'b0, 4'h5, 32'hBBBB0002};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold%0d", i), {rsp_valid, rsp_last, rsp_id, rsp_data}, bcat_exp);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle("t3_done", 100);
    chk("t3_rd_addr", rd_addr, 32'h0000_1230);
    chk("t3_nbeats", nb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_beat%0d", i), bdata[i], rline[i*32 +: 32]);
    end
    chk("t3_last", {blast[3], blast[2], blast[1], blast[0]}, 4'b1000);

    // reserved op is discarded
    clear_mon();
    push({2'b10, 4'h7, 32'hDEAD_BEE0});
    wait_pop("t4_pop");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_busy", busy, 1'b0);
    wait_idle("t4_done", 50);
    chk("t4_pops", npop, 1);
    chk("t4_no_mem", {nrd[7:0], nwr[7:0]}, 16'd0);
    chk("t4_no_rsp", nval, 0);

    // reset during WAIT, then two queued reads
    clear_mon();
    rline = 128'h44444444_33333333_22222222_11111111;
    push({2'b00, 4'h2, 32'h0000_0100});
    wait_pop("t5_pop");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_ctl", {q_pop_en, wr_ready, mem_rd_en, mem_wr_en, rsp_valid, rsp_last, busy}, 7'd0);
    chk("t5_rst_data", {mem_addr, rsp_id, rsp_data}, 68'd0);
    chk("t5_rst_wdata", mem_wdata, 128'd0);
    push({2'b00, 4'h8, 32'h0000_0040});
    push({2'b00, 4'h9, 32'h0000_0080});
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 1'b1;
    n = cyc;
    wait_idle("t5_done", 200);
    chk("t5_first_pop", (pop_cyc[0] - n) >= 1, 1'b1);
    chk("t5_pops", npop, 2);
    chk("t5_rd_cnt", nrd, 2);
    chk("t5_no_wr", nwr, 0);
    chk("t5_nbeats", nb, 8);
    chk("t5_ids", {bid[0], bid[3], bid[4], bid[7]}, 16'h8899);

    // three back-to-back reads
    clear_mon();
    push({2'b00, 4'hA, 32'h0000_1000});
    push({2'b00, 4'hB, 32'h0000_2000});
    push({2'b00, 4'hC, 32'h0000_3000});
    wait_idle("t6_done", 300);
    chk("t6_pops", npop, 3);
    chk("t6_nbeats", nb, 12);
    chk("t6_nlast", nlast, 3);
    chk("t6_order1", pop_cyc[1] > last_cyc[0], 1'b1);
    chk("t6_order2", pop_cyc[2] > last_cyc[1], 1'b1);
    chk("t6_ids", {bid[0], bid[4], bid[8]}, 12'hABC);
    chk("t6_rd_addr", rd_addr, 32'h0000_3000);

    chk("strobe_excl", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
